// File: rtl/neureka_stream_router.sv
// neureka_stream_router
// NB_CH streamer channels share a single TCDM-style load/store port.
// The winner is chosen either by a static select or by round-robin. Each
// handshake pushes a {wen, channel} tag into a small FIFO. In-order read
// responses pop that FIFO and are steered back to the channel that issued
// them. Write responses are consumed and are not forwarded.
// Optional build macro: NEUREKA_ROUTER_PERF_EN enables the per-channel
// handshake counters and the stall counter. When the macro is not defined,
// the counters are not built and both perf outputs are tied to zero.
module neureka_stream_router #(
    parameter int NB_CH   = 4,
    parameter int DW      = 256,
    parameter int AW      = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         mode_i,
    input  logic [$clog2(NB_CH)-1:0]     sel_i,
    input  logic [NB_CH-1:0]             ch_req_i,
    output logic [NB_CH-1:0]             ch_gnt_o,
    input  logic [NB_CH-1:0]             ch_wen_i,
    input  logic [NB_CH*AW-1:0]          ch_add_i,
    input  logic [NB_CH*DW-1:0]          ch_data_i,
    input  logic [NB_CH*DW/8-1:0]        ch_be_i,
    output logic [NB_CH-1:0]             ch_r_valid_o,
    output logic [DW-1:0]                ch_r_data_o,
    output logic                         mem_req_o,
    input  logic                         mem_gnt_i,
    output logic                         mem_wen_o,
    output logic [AW-1:0]                mem_add_o,
    output logic [DW-1:0]                mem_data_o,
    output logic [DW/8-1:0]              mem_be_o,
    input  logic                         mem_r_valid_i,
    input  logic [DW-1:0]                mem_r_data_i,
    output logic                         idle_o,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
    output logic                         err_o,
    output logic [NB_CH*32-1:0]          perf_gnt_o,
    output logic [31:0]                  perf_stall_o
);

    localparam int CHW = $clog2(NB_CH);
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int BW  = DW / 8;

    typedef struct packed {
        logic           wen;
        logic [CHW-1:0] ch;
    } tag_t;

    // Per-channel views of the packed request fields
    logic [AW-1:0] ch_add_arr  [NB_CH];
    logic [DW-1:0] ch_data_arr [NB_CH];
    logic [BW-1:0] ch_be_arr   [NB_CH];

    // Registered state
    logic [CW-1:0]  count_q,   count_d;
    logic [PW-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,  rd_ptr_d;
    logic           lock_q,    lock_d;
    logic [CHW-1:0] lock_ch_q, lock_ch_d;
    logic           err_q,     err_d;
    logic [CHW-1:0] rr_ptr_q,  rr_ptr_d;
    logic           mode_q,    mode_d;
    logic [CHW-1:0] sel_q,     sel_d;
    tag_t           tag_mem_q [MAX_OUT];

    logic [CHW-1:0] rr_win;
    logic [CHW-1:0] rr_idx;
    logic [CHW-1:0] win;
    logic           full;
    logic           hs;
    logic           pop;
    tag_t           head;

    genvar gi;
    generate
        for (gi = 0; gi < NB_CH; gi++) begin : g_unpack
            assign ch_add_arr[gi]  = ch_add_i[gi*AW +: AW];
            assign ch_data_arr[gi] = ch_data_i[gi*DW +: DW];
            assign ch_be_arr[gi]   = ch_be_i[gi*BW +: BW];
        end
    endgenerate

    // Round-robin search: first requester strictly after rr_ptr_q, wrapping modulo NB_CH
    always_comb begin
        rr_win = rr_ptr_q;
        rr_idx = '0;
        for (int k = NB_CH; k >= 1; k--) begin
            rr_idx = CHW'((int'(rr_ptr_q) + k) % NB_CH);
            if (ch_req_i[rr_idx]) begin
                rr_win = rr_idx;
            end
        end
    end

    // While a stalled request is pending, the locked channel keeps ownership of the port
    assign win  = lock_q ? lock_ch_q : (mode_q ? rr_win : sel_q);
    // Use the registered count only; a response in the same cycle does not free a slot
    assign full = (count_q == CW'(MAX_OUT));
    assign hs   = mem_req_o & mem_gnt_i;
    assign pop  = mem_r_valid_i & (count_q != '0);
    assign head = tag_mem_q[rd_ptr_q];

    assign mem_req_o  = ch_req_i[win] & ~full;
    assign mem_wen_o  = ch_wen_i[win];
    assign mem_add_o  = ch_add_arr[win];
    assign mem_data_o = ch_data_arr[win];
    assign mem_be_o   = ch_be_arr[win];

    generate
        for (gi = 0; gi < NB_CH; gi++) begin : g_route
            assign ch_gnt_o[gi]     = hs & (win == CHW'(gi));
            assign ch_r_valid_o[gi] = pop & head.wen & (head.ch == CHW'(gi));
        end
    endgenerate

    assign ch_r_data_o   = mem_r_data_i;
    assign idle_o        = (count_q == '0) & ~|ch_req_i;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    // Next-state logic: FIFO pointers and count, lock, arbitration pointer, config latch, error
    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        mode_d    = mode_q;
        sel_d     = sel_q;
        err_d     = err_q | (mem_r_valid_i & (count_q == '0));

        if (hs) begin
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PW'(1);
            rr_ptr_d = win;
            lock_d   = 1'b0;
        end else if (mem_req_o) begin
            lock_d    = 1'b1;
            lock_ch_d = win;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({hs, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Configuration only follows the inputs while the port is completely quiet
        if ((count_q == '0) && !lock_q) begin
            mode_d = mode_i;
            sel_d  = sel_i;
        end
    end

    // Control state registers; soft clear behaves like reset for everything here
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            err_q     <= 1'b0;
            rr_ptr_q  <= CHW'(NB_CH - 1);
            mode_q    <= 1'b0;
            sel_q     <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            err_q     <= err_d;
            rr_ptr_q  <= rr_ptr_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
        end
    end

    // Tag storage; entries are only read while the count says they are valid
    always_ff @(posedge clk_i) begin
        if (hs) begin
            tag_mem_q[wr_ptr_q] <= '{wen: mem_wen_o, ch: win};
        end
    end

`ifdef NEUREKA_ROUTER_PERF_EN
    logic [31:0] perf_stall_q;

    generate
        for (gi = 0; gi < NB_CH; gi++) begin : g_perf
            logic [31:0] gnt_cnt_q;
            // Handshake counter for one channel; only hard reset clears it
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    gnt_cnt_q <= '0;
                end else if (ch_gnt_o[gi]) begin
                    gnt_cnt_q <= gnt_cnt_q + 32'd1;
                end
            end
            assign perf_gnt_o[gi*32 +: 32] = gnt_cnt_q;
        end
    endgenerate

    // Cycles in which the memory holds off a pending request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
        end else if (mem_req_o && !mem_gnt_i) begin
            perf_stall_q <= perf_stall_q + 32'd1;
        end
    end
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_gnt_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_neureka_stream_router.sv
// Testbench for neureka_stream_router: directed scenarios and a randomized run.
// Every cycle is compared against a queue-based reference model.
module tb_neureka_stream_router;

    localparam int NB_CH   = 4;
    localparam int DW      = 256;
    localparam int AW      = 32;
    localparam int MAX_OUT = 4;

    logic                  clk = 1'b0;
    logic                  rst, clr, mode;
    logic [1:0]            sel;
    logic [NB_CH-1:0]      ch_req, ch_gnt, ch_wen, ch_r_valid;
    logic [NB_CH*AW-1:0]   ch_add;
    logic [NB_CH*DW-1:0]   ch_data;
    logic [NB_CH*DW/8-1:0] ch_be;
    logic [DW-1:0]         ch_r_data;
    logic                  mem_req, mem_gnt, mem_wen, mem_rv;
    logic [AW-1:0]         mem_add;
    logic [DW-1:0]         mem_data, mem_rdata;
    logic [DW/8-1:0]       mem_be;
    logic                  idle, err;
    logic [2:0]            outstanding;
    logic [NB_CH*32-1:0]   perf_gnt;
    logic [31:0]           perf_stall;

    always #5 clk = ~clk;

    neureka_stream_router #(
        .NB_CH(NB_CH), .DW(DW), .AW(AW), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .mode_i(mode), .sel_i(sel),
        .ch_req_i(ch_req), .ch_gnt_o(ch_gnt), .ch_wen_i(ch_wen), .ch_add_i(ch_add),
        .ch_data_i(ch_data), .ch_be_i(ch_be), .ch_r_valid_o(ch_r_valid), .ch_r_data_o(ch_r_data),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_wen_o(mem_wen), .mem_add_o(mem_add),
        .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_r_valid_i(mem_rv), .mem_r_data_i(mem_rdata),
        .idle_o(idle), .outstanding_o(outstanding), .err_o(err),
        .perf_gnt_o(perf_gnt), .perf_stall_o(perf_stall)
    );

    // Reference model state
    logic [2:0]  m_q[$];          // {wen, channel} of each in-flight request, oldest first
    bit          m_lock;
    int          m_lock_ch;
    int          m_rr;
    bit          m_mode;
    int          m_sel;
    bit          m_err;
    logic [31:0] m_pg [NB_CH];
    logic [31:0] m_ps;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit auto_rsp = 1'b0;

    // DUT values sampled mid-cycle, for the directed checks
    logic [NB_CH-1:0] s_gnt, s_rv;
    logic             s_req, s_idle, s_err;
    logic [2:0]       s_out;
    logic [DW-1:0]    s_rdata;
    logic [AW-1:0]    s_add;
    logic [31:0]      s_stall;

    task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input bit hard);
        m_q.delete();
        m_lock    = 1'b0;
        m_lock_ch = 0;
        m_rr      = NB_CH - 1;
        m_mode    = 1'b0;
        m_sel     = 0;
        m_err     = 1'b0;
        if (hard) begin
            foreach (m_pg[i]) m_pg[i] = '0;
            m_ps = '0;
        end
    endtask

    function automatic int model_win();
        if (m_lock) return m_lock_ch;
        if (!m_mode) return m_sel;
        for (int k = 1; k <= NB_CH; k++) begin
            if (ch_req[(m_rr + k) % NB_CH]) return (m_rr + k) % NB_CH;
        end
        return 0;
    endfunction

    // One clock cycle: inputs are already set. Check at the negedge, then advance the model.
    task automatic cycle();
        int               w;
        bit               ereq, ehs, pre_lock;
        int               pre_cnt;
        logic [NB_CH-1:0] egnt, erv;
        logic [2:0]       head;
        logic [NB_CH*32-1:0] epg;
        logic [31:0]      eps;
        if (auto_rsp) begin
            mem_rv    = (m_q.size() > 0);
            mem_rdata = {8{$urandom()}};
        end
        @(negedge clk);
        w    = model_win();
        ereq = ch_req[w] && (m_q.size() < MAX_OUT);
        ehs  = ereq && mem_gnt;
        egnt = '0;
        if (ehs) egnt[w] = 1'b1;
        erv = '0;
        if (mem_rv && m_q.size() > 0) begin
            head = m_q[0];
            if (head[2]) erv[head[1:0]] = 1'b1;
        end
        epg = '0;
        eps = '0;
`ifdef NEUREKA_ROUTER_PERF_EN
        for (int i = 0; i < NB_CH; i++) epg[i*32 +: 32] = m_pg[i];
        eps = m_ps;
`endif
        s_gnt = ch_gnt; s_rv = ch_r_valid; s_req = mem_req; s_idle = idle; s_err = err;
        s_out = outstanding; s_rdata = ch_r_data; s_add = mem_add; s_stall = perf_stall;
        if (chk_en) begin
            check_value("ch_gnt", ch_gnt, egnt);
            check_value("mem_req", mem_req, ereq);
            if (ereq) begin
                check_value("mem_wen", mem_wen, ch_wen[w]);
                check_value("mem_add", mem_add, ch_add[w*AW +: AW]);
                check_value("mem_data", mem_data, ch_data[w*DW +: DW]);
                check_value("mem_be", mem_be, ch_be[w*(DW/8) +: DW/8]);
            end
            check_value("ch_r_valid", ch_r_valid, erv);
            check_value("ch_r_data", ch_r_data, mem_rdata);
            check_value("idle", idle, (m_q.size() == 0) && (ch_req == '0));
            check_value("outstanding", outstanding, m_q.size());
            check_value("err", err, m_err);
            check_value("perf_gnt", perf_gnt, epg);
            check_value("perf_stall", perf_stall, eps);
        end
        if (rst) begin
            model_reset(1'b1);
        end else begin
            if (ehs) m_pg[w] = m_pg[w] + 32'd1;
            if (ereq && !mem_gnt) m_ps = m_ps + 32'd1;
            if (clr) begin
                model_reset(1'b0);
            end else begin
                pre_lock = m_lock;
                pre_cnt  = m_q.size();
                if (mem_rv) begin
                    if (m_q.size() > 0) void'(m_q.pop_front());
                    else m_err = 1'b1;
                end
                if (ehs) begin
                    m_q.push_back({ch_wen[w], 2'(w)});
                    m_rr   = w;
                    m_lock = 1'b0;
                end else if (ereq) begin
                    m_lock    = 1'b1;
                    m_lock_ch = w;
                end
                if (pre_cnt == 0 && !pre_lock) begin
                    m_mode = mode;
                    m_sel  = int'(sel);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NB_CH; i++) begin
            ch_add[i*AW +: AW] = $urandom();
            ch_be[i*(DW/8) +: DW/8] = {$urandom(), $urandom()};
            for (int j = 0; j < DW / 32; j++) ch_data[i*DW + j*32 +: 32] = $urandom();
        end
    endtask

    initial begin : stim
        int ord [5];
        logic [31:0] st0;
        logic [3:0]  one_hot;
        ord = '{0, 1, 2, 3, 0};
        rst = 1'b1; clr = 1'b0; mode = 1'b0; sel = '0;
        ch_req = '0; ch_wen = '0; ch_add = '0; ch_data = '0; ch_be = '0;
        mem_gnt = 1'b0; mem_rv = 1'b0; mem_rdata = '0;
        rand_fields();
        cycle();
        cycle();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        cycle();
        check_value("rst_idle", s_idle, 1'b1);
        check_value("rst_outstanding", s_out, 3'd0);
        check_value("rst_err", s_err, 1'b0);
        check_value("rst_mem_req", s_req, 1'b0);

        // Static select of channel 2 with every channel requesting
        mode = 1'b0; sel = 2'd2;
        cycle();
        ch_req = 4'hF; ch_wen = 4'hF; mem_gnt = 1'b1; auto_rsp = 1'b1;
        repeat (6) begin
            cycle();
            check_value("static_gnt", s_gnt, 4'b0100);
        end
        ch_req = '0;
        cycle();

        // Round-robin from a cleared pointer
        clr = 1'b1; mode = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        ch_req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            cycle();
            one_hot = 4'b0001 << ord[i];
            check_value("rr_gnt", s_gnt, one_hot);
        end
        ch_req = '0;
        cycle();

        // Outstanding limit, no bypass when a slot frees in the same cycle
        clr = 1'b1; mode = 1'b0; sel = 2'd0;
        cycle();
        clr = 1'b0; auto_rsp = 1'b0; mem_rv = 1'b0;
        ch_req = 4'b0001; ch_wen = 4'b0001; mem_gnt = 1'b1;
        repeat (4) begin
            cycle();
            check_value("fill_gnt", s_gnt, 4'b0001);
        end
        cycle();
        check_value("full_mask", s_req, 1'b0);
        check_value("full_count", s_out, 3'd4);
        mem_rv = 1'b1;
        cycle();
        check_value("full_nobypass", s_req, 1'b0);
        check_value("full_rsp", s_rv, 4'b0001);
        mem_rv = 1'b0;
        cycle();
        check_value("refill_gnt", s_gnt, 4'b0001);
        ch_req = '0; auto_rsp = 1'b1;
        repeat (5) cycle();

        // Lock while the memory stalls; a newcomer cannot steal the port
        clr = 1'b1; mode = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        mem_gnt = 1'b0; ch_req = 4'b0010;
        cycle();
        st0 = s_stall;
        ch_req = 4'b0011;
        cycle();
        cycle();
        check_value("lock_add", s_add, ch_add[1*AW +: AW]);
        mem_gnt = 1'b1;
        cycle();
        check_value("lock_gnt", s_gnt, 4'b0010);
`ifdef NEUREKA_ROUTER_PERF_EN
        check_value("stall_delta", s_stall - st0, 32'd3);
`else
        check_value("stall_delta", s_stall - st0, 32'd0);
`endif
        cycle();
        check_value("rr_after_lock", s_gnt, 4'b0001);
        ch_req = '0;
        repeat (3) cycle();

        // A write followed by a read; only the read response is forwarded
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        auto_rsp = 1'b0; mem_rv = 1'b0;
        ch_req = 4'b0001; ch_wen = 4'b1000; mem_gnt = 1'b1;
        cycle();
        check_value("wr_gnt", s_gnt, 4'b0001);
        ch_req = 4'b1000; mem_rv = 1'b1; mem_rdata = {8{$urandom()}};
        cycle();
        check_value("wr_rsp_drop", s_rv, 4'b0000);
        check_value("rd_gnt", s_gnt, 4'b1000);
        ch_req = '0; mem_rdata = {32{8'hA5}};
        cycle();
        check_value("rd_rv", s_rv, 4'b1000);
        check_value("rd_data", s_rdata, {32{8'hA5}});

        // Stray response sets the sticky error; soft clear removes it
        cycle();
        check_value("stray_rv", s_rv, 4'b0000);
        mem_rv = 1'b0;
        cycle();
        check_value("err_set", s_err, 1'b1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        check_value("clr_err", s_err, 1'b0);
        check_value("clr_idle", s_idle, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ch_req  = 4'($urandom());
            ch_wen  = 4'($urandom());
            mem_gnt = ($urandom_range(0, 3) != 0);
            mem_rv  = (m_q.size() > 0) ? 1'($urandom()) : ($urandom_range(0, 49) == 0);
            mem_rdata = {8{$urandom()}};
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel = 2'($urandom());
            clr = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 299) == 0);
            rand_fields();
            cycle();
        end
        rst = 1'b0; clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
